// File: rtl/cntr_cla_mod_pkg.sv
// Shared constants and types for the modulo up/down counter and its CLA adder.
// Holds direction encoding, look-ahead group size, reset value and the per-edge operation select.
package cntr_cla_mod_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DN       = 1'b0;
  localparam int   CLA_GROUP    = 4;
  localparam int   CNTR_RST_VAL = 0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2
  } cntr_op_e;

endpackage

// File: rtl/cntr_cla_mod_cla.sv
// WIDTH-bit carry look-ahead adder: 4-bit look-ahead groups, group carries rippled.
// WIDTH must be a multiple of CLA_GROUP.
module cla_add_n
  import cntr_cla_mod_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [NG:0] gc;

  assign gc[0] = ci;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [3:0] p;
    logic [3:0] k;
    logic [3:0] c;

    assign p = a[g*4 +: 4] ^ b[g*4 +: 4];
    assign k = a[g*4 +: 4] & b[g*4 +: 4];

    // Carries inside the group are flattened, not rippled.
    assign c[0] = gc[g];
    assign c[1] = k[0] | (p[0] & gc[g]);
    assign c[2] = k[1] | (p[1] & k[0]) | (p[1] & p[0] & gc[g]);
    assign c[3] = k[2] | (p[2] & k[1]) | (p[2] & p[1] & k[0])
                | (p[2] & p[1] & p[0] & gc[g]);
    assign gc[g+1] = k[3] | (p[3] & k[2]) | (p[3] & p[2] & k[1])
                   | (p[3] & p[2] & p[1] & k[0])
                   | (p[3] & p[2] & p[1] & p[0] & gc[g]);

    assign sum[g*4 +: 4] = p ^ c;
  end

  assign co = gc[NG];

endmodule

// File: rtl/cntr_cla_mod.sv
// Modulo up/down counter with programmable step, parallel load, tc pulse and sticky ovf.
// Define CNTR_CLA_SATURATE_EN to clamp at the limits instead of wrapping.
module cntr_cla_mod
  import cntr_cla_mod_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH <= 0) begin : g_width_chk
    $error("cntr_cla_mod: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] up_sum;
  logic             up_co;
  logic [WIDTH-1:0] dn_diff;
  logic             dn_co;
  logic [WIDTH-1:0] cmp_diff_unused;
  logic             cmp_co;

  logic             over;
  logic             borrow;
  logic             step_nz;
  logic             event_hit;
  cntr_op_e         op;

  cla_add_n #(.WIDTH(WIDTH)) u_add_up (
    .a   (cnt_q),
    .b   (step),
    .ci  (1'b0),
    .sum (up_sum),
    .co  (up_co)
  );

  cla_add_n #(.WIDTH(WIDTH)) u_add_dn (
    .a   (cnt_q),
    .b   (~step),
    .ci  (1'b1),
    .sum (dn_diff),
    .co  (dn_co)
  );

  // max_val - sum: a borrow means the truncated sum lies above the modulus.
  cla_add_n #(.WIDTH(WIDTH)) u_cmp (
    .a   (max_val),
    .b   (~up_sum),
    .ci  (1'b1),
    .sum (cmp_diff_unused),
    .co  (cmp_co)
  );

  assign over    = ~cmp_co;
  assign borrow  = ~dn_co;
  assign step_nz = |step;

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en && step_nz) begin
      op = OP_STEP;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    event_hit = 1'b0;
    case (op)
      OP_LOAD: begin
        cnt_d = (load_val > max_val) ? max_val : load_val;
        ovf_d = 1'b0;
      end
      OP_STEP: begin
        if (up == DIR_UP) begin
          if (up_co || over) begin
            event_hit = 1'b1;
`ifdef CNTR_CLA_SATURATE_EN
            cnt_d = max_val;
            tc_d  = (cnt_q != max_val);
`else
            cnt_d = '0;
            tc_d  = 1'b1;
`endif
          end else begin
            cnt_d = up_sum;
          end
        end else begin
          if (borrow) begin
            event_hit = 1'b1;
`ifdef CNTR_CLA_SATURATE_EN
            cnt_d = '0;
            tc_d  = (cnt_q != '0);
`else
            cnt_d = max_val;
            tc_d  = 1'b1;
`endif
          end else begin
            cnt_d = dn_diff;
          end
        end
        if (event_hit) begin
          ovf_d = 1'b1;
        end else if (clr_ovf) begin
          ovf_d = 1'b0;
        end
      end
      default: begin
        if (clr_ovf) begin
          ovf_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= WIDTH'(CNTR_RST_VAL);
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_cntr_cla_mod.sv
// Self-checking bench for cntr_cla_mod (WIDTH=8): directed scenarios plus randomized
// traffic compared against an integer-arithmetic reference model.
module tb_cntr_cla_mod;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en, up, load, clr_ovf;
  logic [W-1:0] step, max_val, load_val;
  logic [W-1:0] cnt;
  logic         tc, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt = 0;
  int m_tc  = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  cntr_cla_mod #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up       (up),
    .step     (step),
    .max_val  (max_val),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .cnt      (cnt),
    .tc       (tc),
    .ovf      (ovf)
  );

  // Reference: next state from the counter rules using plain integer arithmetic.
  task automatic model_edge();
    int mx, st, s;
    bit ev;
    mx = int'(max_val);
    st = int'(step);
    ev = 0;
    if (!reset_n) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0;
    end else if (load) begin
      m_cnt = (int'(load_val) > mx) ? mx : int'(load_val);
      m_tc  = 0;
      m_ovf = 0;
    end else begin
      m_tc = 0;
      if (en && st != 0) begin
        if (up) begin
          s = m_cnt + st;
          if (s > mx) begin
            ev = 1;
`ifdef CNTR_CLA_SATURATE_EN
            m_tc = (m_cnt != mx); m_cnt = mx;
`else
            m_tc = 1; m_cnt = 0;
`endif
          end else m_cnt = s;
        end else begin
          if (st > m_cnt) begin
            ev = 1;
`ifdef CNTR_CLA_SATURATE_EN
            m_tc = (m_cnt != 0); m_cnt = 0;
`else
            m_tc = 1; m_cnt = mx;
`endif
          end else m_cnt = m_cnt - st;
        end
      end
      if (ev) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; load = 0; clr_ovf = 0; up = 1; step = '0;
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic [W-1:0] mx);
    idle();
    max_val = mx; load_val = v; load = 1;
    tick();
    load = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); max_val = 8'hFF; load_val = '0;
    tick(); tick();
    reset_n = 1;
    do_load(8'h30, 8'hFF);
    en = 1; up = 1; step = 8'h07;
    tick();
    if (cnt !== 8'h37) begin n_fail++; $display("FAIL reset_precount cnt=%h exp=37", cnt); end
    n_checks++;
    #2 reset_n = 0;
    #1;
    if ({cnt, tc, ovf} !== 10'h0) begin
      n_fail++; $display("FAIL reset_async cnt=%h tc=%b ovf=%b exp=0/0/0", cnt, tc, ovf);
    end
    n_checks++;
    m_cnt = 0; m_tc = 0; m_ovf = 0;
    @(posedge clk); #1;
    reset_n = 1; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cnt !== 8'h00 || tc !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold cyc=%0d cnt=%h tc=%b exp=00/0", i, cnt, tc);
      end
      n_checks++;
    end
  endtask

  task automatic test_wrap_sequence();
    logic [W-1:0] exp_seq [12] = '{8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8,8'd9,8'd0,8'd1,8'd2};
    do_load(8'd0, 8'd9);
    en = 1; up = 1; step = 8'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cnt !== exp_seq[i] || tc !== (i == 9)) begin
        n_fail++;
        $display("FAIL wrap_seq cyc=%0d cnt=%0d tc=%b exp=%0d/%b", i, cnt, tc, exp_seq[i], (i == 9));
      end
      n_checks++;
    end
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_seq_ovf ovf=%b exp=1", ovf); end
    n_checks++;
  endtask

  task automatic test_carry_out();
    do_load(8'hFE, 8'hFF);
    en = 1; up = 1; step = 8'd3;
    tick();
    if (cnt !== 8'h00 || tc !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL carry_out cnt=%h tc=%b ovf=%b exp=00/1/1", cnt, tc, ovf);
    end
    n_checks++;
    en = 0;
    tick();
    if (tc !== 1'b0 || cnt !== 8'h00) begin
      n_fail++; $display("FAIL carry_tc_drop cnt=%h tc=%b exp=00/0", cnt, tc);
    end
    n_checks++;
  endtask

  task automatic test_down_borrow();
    logic [W-1:0] exp_c;
    do_load(8'd2, 8'd20);
    en = 1; up = 0; step = 8'd5;
    tick();
`ifdef CNTR_CLA_SATURATE_EN
    exp_c = 8'd0;
`else
    exp_c = 8'd20;
`endif
    if (cnt !== exp_c || tc !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL down_borrow cnt=%0d tc=%b ovf=%b exp=%0d/1/1", cnt, tc, ovf, exp_c);
    end
    n_checks++;
    tick();
    if (cnt !== m_cnt[W-1:0] || tc !== m_tc[0]) begin
      n_fail++; $display("FAIL down_repeat cnt=%0d tc=%b exp=%0d/%0d", cnt, tc, m_cnt, m_tc);
    end
    n_checks++;
  endtask

  task automatic test_load();
    idle();
    load = 1; en = 1; up = 1; step = 8'd1; load_val = 8'h50; max_val = 8'h40;
    tick();
    load = 0; en = 0;
    if (cnt !== 8'h40 || tc !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL load_clamp cnt=%h tc=%b ovf=%b exp=40/0/0", cnt, tc, ovf);
    end
    n_checks++;
  endtask

  task automatic test_ovf_clear();
    do_load(8'd0, 8'd0);
    en = 1; up = 1; step = 8'd1;
    tick();
    if (cnt !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL max0_wrap cnt=%h tc=%b ovf=%b exp=00/1/1", cnt, tc, ovf);
    end
    n_checks++;
    clr_ovf = 1;
    tick();
    if (ovf !== 1'b1 || tc !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins ovf=%b tc=%b exp=1/1", ovf, tc);
    end
    n_checks++;
    en = 0;
    tick();
    clr_ovf = 0;
    if (ovf !== 1'b0 || tc !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear ovf=%b tc=%b exp=0/0", ovf, tc);
    end
    n_checks++;
  endtask

  task automatic test_boundaries();
    do_load(8'd5, 8'd9);
    max_val = 8'd3; en = 1; up = 1; step = 8'd0;
    tick();
    if (cnt !== 8'd5 || tc !== 1'b0) begin
      n_fail++; $display("FAIL step0_hold cnt=%0d tc=%b exp=5/0", cnt, tc);
    end
    n_checks++;
    step = 8'd1;
    tick();
    if (cnt !== 8'd0 || tc !== 1'b1) begin
      n_fail++; $display("FAIL above_max_up cnt=%0d tc=%b exp=0/1", cnt, tc);
    end
    n_checks++;
    do_load(8'd8, 8'd9);
    max_val = 8'd3; en = 1; up = 0; step = 8'd2;
    tick();
    if (cnt !== 8'd6 || tc !== 1'b0) begin
      n_fail++; $display("FAIL above_max_down cnt=%0d tc=%b exp=6/0", cnt, tc);
    end
    n_checks++;
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom);
      max_val  = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      step     = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) step = W'($urandom);
      tick();
      if (cnt !== m_cnt[W-1:0] || tc !== m_tc[0] || ovf !== m_ovf[0]) begin
        n_fail++;
        $display("FAIL random cyc=%0d cnt=%h tc=%b ovf=%b exp=%h/%0d/%0d",
                 i, cnt, tc, ovf, m_cnt[W-1:0], m_tc, m_ovf);
      end
      n_checks++;
    end
    idle();
  endtask

  initial begin
    reset_n = 0; idle(); max_val = '0; load_val = '0;
    test_reset();
    test_wrap_sequence();
    test_carry_out();
    test_down_borrow();
    test_load();
    test_ovf_clear();
    test_boundaries();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
